id_stage: RTL and testbench

//  Decode/operand-fetch stage, directly upstream of reg_file: decodes MIPS-I instr, drives raddr1/raddr2,

---
 rtl/id_stage_pkg.sv | 66 ++++++
 rtl/id_scoreboard.sv | 49 ++++
 rtl/id_stage.sv | 123 ++++++++++++
 tb/tb_id_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared constants and the instruction decode helper for the ID stage.
// Decode only: operand bypass from writeback is selected by WB_BYPASS_EN in id_stage.
package id_stage_pkg;

    localparam int ID_DATA_WIDTH = 32;
    localparam int ID_ADDR_WIDTH = 5;
    localparam logic [4:0] REG_RA = 5'd31;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_OR   = 6'h25;

    typedef struct packed {
        logic       uses_rs;
        logic       uses_rt;
        logic       wen;
        logic [4:0] dst;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [5:0] op;
        op = instr[31:26];
        d  = '0;
        if (op == OP_SPECIAL) begin
            d.uses_rs = 1'b1;
            d.uses_rt = 1'b1;
            d.dst     = instr[15:11];
        end else if ((op >= OP_ADDI && op <= OP_LUI) || (op >= OP_LB && op <= OP_LHU)) begin
            d.uses_rs = 1'b1;
            d.dst     = instr[20:16];
        end else if ((op >= OP_SB && op <= OP_SW) || op == OP_BEQ || op == OP_BNE) begin
            d.uses_rs = 1'b1;
            d.uses_rt = 1'b1;
        end else if (op == OP_BLEZ || op == OP_BGTZ || op == OP_REGIMM) begin
            d.uses_rs = 1'b1;
        end else if (op == OP_JAL) begin
            d.dst = REG_RA;
        end
        // r0 is never tracked, so an r0 destination writes nothing.
        d.wen = (d.dst != 5'd0);
        return d;
    endfunction

    function automatic logic zero_ext_imm(input logic [5:0] op);
        return (op >= OP_ANDI) && (op <= OP_XORI);
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, r0 never busy.
// A set and a clear of the same index on one edge leaves the bit set.
module id_scoreboard
    import id_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = ID_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    input  logic [ADDR_WIDTH-1:0] rd2_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    output logic                  rd1_busy,
    output logic                  rd2_busy,
    output logic                  dst_busy
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] sb_next;

    always_comb begin
        sb_next = sb;
        if (clr_en && clr_addr != '0) begin
            sb_next[clr_addr] = 1'b0;
        end
        if (set_en) begin
            sb_next[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    assign rd1_busy = sb[rd1_addr] && (rd1_addr != '0);
    assign rd2_busy = sb[rd2_addr] && (rd2_addr != '0);
    assign dst_busy = sb[dst_addr] && (dst_addr != '0);

endmodule

// File: rtl/id_stage.sv
// MIPS-I decode / operand-fetch stage with a scoreboard interlock toward EX.
// Option macro WB_BYPASS_EN: forward writeback data to a source read in the same cycle.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int DATA_WIDTH = ID_DATA_WIDTH,
    parameter int ADDR_WIDTH = ID_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [31:0]           in_pc,
    output logic [ADDR_WIDTH-1:0] raddr1,
    output logic [ADDR_WIDTH-1:0] raddr2,
    input  logic [DATA_WIDTH-1:0] rdata1,
    input  logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  wb_wen,
    input  logic [ADDR_WIDTH-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [5:0]            out_op,
    output logic [5:0]            out_funct,
    output logic [ADDR_WIDTH-1:0] out_dst,
    output logic                  out_wen,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic [DATA_WIDTH-1:0] out_imm
);

    // Handshake: a transfer happens on a posedge where valid && ready are both high;
    // valid never waits on ready, and out_* stay stable while out_valid && !out_ready.

    dec_t                  dec;
    logic [ADDR_WIDTH-1:0] rs, rt, dst;
    logic [5:0]            op;
    logic                  rs_busy, rt_busy, dst_busy;
    logic                  rs_haz, rt_haz, stall, accept;
    logic [DATA_WIDTH-1:0] op_a, op_b, imm_ext;

    assign op     = in_instr[31:26];
    assign rs     = in_instr[21 +: ADDR_WIDTH];
    assign rt     = in_instr[16 +: ADDR_WIDTH];
    assign dec    = decode(in_instr);
    assign dst    = dec.dst;
    assign raddr1 = rs;
    assign raddr2 = rt;

    assign wen   = wb_wen;
    assign waddr = wb_waddr;
    assign wdata = wb_wdata;

    assign imm_ext = zero_ext_imm(op) ? {{(DATA_WIDTH-16){1'b0}}, in_instr[15:0]}
                                      : {{(DATA_WIDTH-16){in_instr[15]}}, in_instr[15:0]};

    id_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (accept && dec.wen),
        .set_addr (dst),
        .clr_en   (wb_wen),
        .clr_addr (wb_waddr),
        .rd1_addr (rs),
        .rd2_addr (rt),
        .dst_addr (dst),
        .rd1_busy (rs_busy),
        .rd2_busy (rt_busy),
        .dst_busy (dst_busy)
    );

`ifdef WB_BYPASS_EN
    logic wb_hit_rs, wb_hit_rt;
    assign wb_hit_rs = wb_wen && (wb_waddr == rs) && (rs != '0);
    assign wb_hit_rt = wb_wen && (wb_waddr == rt) && (rt != '0);
    assign rs_haz    = dec.uses_rs && rs_busy && !wb_hit_rs;
    assign rt_haz    = dec.uses_rt && rt_busy && !wb_hit_rt;
    assign op_a      = wb_hit_rs ? wb_wdata : rdata1;
    assign op_b      = wb_hit_rt ? wb_wdata : rdata2;
`else
    // The register file updates on the same edge, so a source being written back stays busy.
    assign rs_haz = dec.uses_rs && rs_busy;
    assign rt_haz = dec.uses_rt && rt_busy;
    assign op_a   = rdata1;
    assign op_b   = rdata2;
`endif

    assign stall    = rs_haz || rt_haz || (dec.wen && dst_busy);
    assign in_ready = rst && !stall && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_op    <= '0;
            out_funct <= '0;
            out_dst   <= '0;
            out_wen   <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_imm   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_op    <= op;
            out_funct <= in_instr[5:0];
            out_dst   <= dst;
            out_wen   <= dec.wen;
            out_a     <= op_a;
            out_b     <= op_b;
            out_imm   <= imm_ext;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed hazard/immediate scenarios, then random traffic,
// all checked every cycle against a queue-based model of pending writes.
module tb_id_stage;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        out_valid, out_ready;
    logic [31:0] out_pc;
    logic [5:0]  out_op, out_funct;
    logic [4:0]  out_dst;
    logic        out_wen;
    logic [31:0] out_a, out_b, out_imm;

    always #5 clk = ~clk;

    // Register file model, read by instruction field, written on the writeback edge.
    logic [31:0] rf [32];
    assign rdata1 = rf[in_instr[25:21]];
    assign rdata2 = rf[in_instr[20:16]];

    id_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .wen(wen), .waddr(waddr), .wdata(wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
        .out_funct(out_funct), .out_dst(out_dst), .out_wen(out_wen),
        .out_a(out_a), .out_b(out_b), .out_imm(out_imm)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: EX-bound register contents and the list of registers awaiting writeback.
    logic        m_valid;
    logic [31:0] m_pc, m_a, m_b, m_imm;
    logic [5:0]  m_op, m_funct;
    logic [4:0]  m_dst;
    logic        m_wen;
    logic [4:0]  pend_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (pend_q[i]) if (pend_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    // Source usage and destination straight from the MIPS-I opcode table.
    task automatic ref_decode(input logic [31:0] ins, output bit urs, output bit urt,
                              output logic [4:0] d);
        int op;
        op  = int'(ins[31:26]);
        urs = 0; urt = 0; d = 5'd0;
        if (op == 0) begin urs = 1; urt = 1; d = ins[15:11]; end
        else if (op >= 8 && op <= 15) begin urs = 1; d = ins[20:16]; end
        else if (op >= 32 && op <= 37) begin urs = 1; d = ins[20:16]; end
        else if (op >= 40 && op <= 43) begin urs = 1; urt = 1; end
        else if (op == 4 || op == 5) begin urs = 1; urt = 1; end
        else if (op == 1 || op == 6 || op == 7) urs = 1;
        else if (op == 3) d = 5'd31;
    endtask

    function automatic logic [31:0] r_type(input int s, input int t, input int d, input int fn);
        logic [31:0] w;
        w = {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(fn)};
        return w;
    endfunction

    function automatic logic [31:0] i_type(input int op, input int s, input int t, input int imm);
        logic [31:0] w;
        w = {6'(op), 5'(s), 5'(t), 16'(imm)};
        return w;
    endfunction

    function automatic logic [31:0] rand_instr();
        int ops [23] = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 12, 13, 14, 15,
                         32, 35, 37, 40, 43, 63};
        int op;
        op = ops[$urandom_range(0, 22)];
        return {6'(op), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63))};
    endfunction

    // One clock: check everything against the model, then advance the model.
    task automatic cycle();
        bit          urs, urt, hit_rs, hit_rt, stall, exp_rdy, acc;
        logic [4:0]  d, rs, rt;
        logic [31:0] ea, eb, eimm;
        int          op;
        #1;
        rs = in_instr[25:21];
        rt = in_instr[20:16];
        ref_decode(in_instr, urs, urt, d);
        hit_rs  = wb_wen && wb_waddr == rs && rs != 0;
        hit_rt  = wb_wen && wb_waddr == rt && rt != 0;
        stall   = (urs && is_pending(rs) && !(BYP && hit_rs)) ||
                  (urt && is_pending(rt) && !(BYP && hit_rt)) || is_pending(d);
        exp_rdy = rst && !stall && (!m_valid || out_ready);
        acc     = in_valid && exp_rdy;
        ea   = (BYP && hit_rs) ? wb_wdata : rf[rs];
        eb   = (BYP && hit_rt) ? wb_wdata : rf[rt];
        op   = int'(in_instr[31:26]);
        eimm = (op >= 12 && op <= 14) ? {16'h0, in_instr[15:0]}
                                      : {{16{in_instr[15]}}, in_instr[15:0]};

        check("in_ready", in_ready, exp_rdy);
        check("raddr1", raddr1, rs);
        check("raddr2", raddr2, rt);
        check("rf_wen", wen, wb_wen);
        check("rf_waddr", waddr, wb_waddr);
        check("rf_wdata", wdata, wb_wdata);
        check("out_valid", out_valid, m_valid);
        check("out_pc", out_pc, m_pc);
        check("out_op", out_op, m_op);
        check("out_funct", out_funct, m_funct);
        check("out_dst", out_dst, m_dst);
        check("out_wen", out_wen, m_wen);
        check("out_a", out_a, m_a);
        check("out_b", out_b, m_b);
        check("out_imm", out_imm, m_imm);

        @(posedge clk);
        #1;
        if (!rst) begin
            m_valid = 0; m_pc = 0; m_op = 0; m_funct = 0; m_dst = 0; m_wen = 0;
            m_a = 0; m_b = 0; m_imm = 0;
            pend_q.delete();
        end else begin
            if (wb_wen && wb_waddr != 0) begin
                for (int i = pend_q.size() - 1; i >= 0; i--)
                    if (pend_q[i] == wb_waddr) pend_q.delete(i);
            end
            if (acc) begin
                m_valid = 1; m_pc = in_pc; m_op = in_instr[31:26]; m_funct = in_instr[5:0];
                m_dst = d; m_wen = (d != 0); m_a = ea; m_b = eb; m_imm = eimm;
                if (d != 0) pend_q.push_back(d);
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        if (wb_wen && wb_waddr != 0) rf[wb_waddr] = wb_wdata;
        @(negedge clk);
    endtask

    task automatic do_wb(input int r, input logic [31:0] data);
        in_valid = 0; wb_wen = 1; wb_waddr = 5'(r); wb_wdata = data;
        cycle();
        wb_wen = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'hA000_0000 + 32'(i);
        m_valid = 0; m_pc = 0; m_op = 0; m_funct = 0; m_dst = 0; m_wen = 0;
        m_a = 0; m_b = 0; m_imm = 0;
        rst = 0; in_valid = 1; in_instr = r_type(1, 2, 3, 6'h21); in_pc = 32'h100;
        out_ready = 1; wb_wen = 0; wb_waddr = 0; wb_wdata = 0;
        @(posedge clk); #1; @(negedge clk);

        // Reset held two cycles with a valid instruction offered.
        cycle(); cycle();
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_a", out_a, 0);

        // RAW: addu $3,$1,$2 then addu $4,$3,$3.
        rst = 1;
        cycle();
        in_instr = r_type(3, 3, 4, 6'h21); in_pc = 32'h104;
        cycle(); cycle();
        #1 check("raw_stalled", in_ready, 0);
        out_ready = 0; wb_wen = 1; wb_waddr = 3; wb_wdata = 32'h3333_0003;
        #1 check("raw_wb_cycle_ready", in_ready, BYP);
        cycle();
        wb_wen = 0; in_valid = !BYP;
        cycle();
        #1;
        check("raw_out_pc", out_pc, 32'h104);
        check("raw_out_a", out_a, 32'h3333_0003);
        check("raw_out_b", out_b, 32'h3333_0003);
        out_ready = 1;
        do_wb(4, 32'h4444_0004);

        // Backpressure: hold the output register for five cycles.
        in_valid = 1; in_instr = i_type(9, 0, 5, 1); in_pc = 32'h200;
        cycle();
        out_ready = 0; in_instr = i_type(9, 0, 6, 2); in_pc = 32'h204;
        for (int i = 0; i < 5; i++) begin
            cycle();
            #1;
            check("bp_hold_pc", out_pc, 32'h200);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1;
        cycle();
        #1 check("bp_drain_pc", out_pc, 32'h204);
        in_instr = i_type(9, 0, 8, 3); in_pc = 32'h208;
        cycle();
        #1 check("bp_drain_pc2", out_pc, 32'h208);
        do_wb(5, 32'h5); do_wb(6, 32'h6); do_wb(8, 32'h8);

        // r0 destination and r0 sources.
        in_valid = 1; in_instr = r_type(1, 2, 0, 6'h21); in_pc = 32'h300;
        cycle();
        #1 check("r0_out_wen", out_wen, 0);
        in_instr = r_type(0, 0, 5, 6'h21); in_pc = 32'h304;
        #1 check("r0_no_stall", in_ready, 1);
        cycle();

        // Immediate extension.
        in_instr = i_type(13, 0, 1, 16'h8000); in_pc = 32'h400;
        cycle();
        #1 check("ori_imm", out_imm, 32'h0000_8000);
        in_instr = i_type(9, 0, 2, 16'h8000); in_pc = 32'h404;
        cycle();
        #1 check("addiu_imm", out_imm, 32'hFFFF_8000);
        do_wb(1, 32'h11); do_wb(2, 32'h22); do_wb(5, 32'h55);

        // WAW on $7, then a same-edge clear and set of $7.
        in_valid = 1; in_instr = i_type(35, 0, 7, 0); in_pc = 32'h500;
        cycle();
        in_instr = r_type(3, 4, 7, 6'h21); in_pc = 32'h504;
        #1 check("waw_stalled", in_ready, 0);
        cycle();
        wb_wen = 1; wb_waddr = 7; wb_wdata = 32'h7777_0007;
        #1 check("waw_wb_cycle", in_ready, 0);
        cycle();
        wb_wdata = 32'h7777_0008;
        #1 check("waw_after_clear", in_ready, 1);
        cycle();
        wb_wen = 0; in_instr = r_type(7, 0, 9, 6'h21); in_pc = 32'h508;
        #1 check("set_wins", in_ready, 0);
        cycle();
        do_wb(7, 32'h7777_0009);

        // Random traffic with occasional reset.
        for (int n = 0; n < 4000; n++) begin
            rst       = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            wb_wdata  = $urandom;
            wb_waddr  = 5'($urandom_range(0, 7));
            wb_wen    = ($urandom_range(0, 15) == 0);
            if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb_wen   = 1;
                wb_waddr = pend_q[$urandom_range(0, pend_q.size() - 1)];
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
